// File: rtl/xyz_sched_pkg.sv
//============================================================================
// Module      : xyz_sched_pkg
// Description : Shared types and helpers for the XYZ round-robin scheduler:
//               FSM state encoding, default operand width, and the
//               rotating-pointer increment used by arbiter and top.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package xyz_sched_pkg;

    // Default operand / result width of one XYZ lane
    localparam int W_DEFAULT = 5;

    // Lane-sequencing states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RESULT = 3'd2,
        CHECK  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Next position of a rotating pointer over num slots, wrapping to 0
    function automatic int rr_next(input int idx, input int num);
        return (idx >= num - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xyz_rr_arbiter.sv
//============================================================================
// Module      : xyz_rr_arbiter
// Description : Combinational rotating-priority arbiter. Searches req_valid
//               starting at rr_ptr and wrapping, and returns a one-hot grant,
//               its index, and whether any request was found.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module xyz_rr_arbiter
    import xyz_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [PTR_W-1:0] w_pos;

    // Walk every slot once from rr_ptr; the first valid one wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_pos     = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[w_pos]) begin
                grant_any     = 1'b1;
                grant[w_pos]  = 1'b1;
                grant_idx     = w_pos;
            end
            w_pos = PTR_W'(rr_next(int'(w_pos), NUM_REQ));
        end
    end

endmodule

`default_nettype wire

// File: rtl/xyz_rr_scheduler.sv
//============================================================================
// Module      : xyz_rr_scheduler
// Description : Shares one XYZ lane (start / result / check, RDY/EN) between
//               NUM_REQ requesters in round-robin order. Each accepted
//               operand bundle is sequenced start(a,b) -> result(c) ->
//               check(d) and both captured values are returned to the owner.
//               Optional watchdog: define XYZ_SCHED_TIMEOUT_EN to abort a
//               stalled RESULT/CHECK wait after TO_CYC cycles with resp_err.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module xyz_rr_scheduler
    import xyz_sched_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
`ifdef XYZ_SCHED_TIMEOUT_EN
    ,
    parameter int TO_CYC  = 64
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ*W-1:0] req_c,
    input  logic [NUM_REQ*W-1:0] req_d,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [W-1:0]         resp_result,
    output logic [W-1:0]         resp_check,
    output logic                 resp_err,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [W-1:0]         xyz_start_a,
    output logic [W-1:0]         xyz_start_b,
    output logic                 en_xyz_start,
    input  logic                 rdy_xyz_start,
    output logic [W-1:0]         xyz_result_c,
    input  logic [W-1:0]         xyz_result,
    input  logic                 rdy_xyz_result,
    output logic [W-1:0]         xyz_check_d,
    output logic                 en_xyz_check,
    input  logic [W-1:0]         xyz_check,
    input  logic                 rdy_xyz_check,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_c;
    logic [W-1:0]         r_d;
    logic [W-1:0]         r_res;
    logic [W-1:0]         r_chk;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_PTR_W-1:0]   w_gidx;
    logic                 w_gany;
    logic                 w_accept;
    logic                 w_resp_hs;
    logic                 w_timeout;
    logic                 w_err;

    xyz_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_any (w_gany)
    );

    assign w_accept  = (r_state == IDLE) && w_gany;
    assign w_resp_hs = (r_state == RESP) && resp_ready[r_owner];

`ifdef XYZ_SCHED_TIMEOUT_EN
    localparam int c_TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    logic [c_TO_W-1:0] r_to;
    logic              r_err;

    // Abort only when the limit is reached and the awaited RDY is still low
    assign w_timeout = (r_to == c_TO_W'(TO_CYC - 1)) &&
                       (((r_state == RESULT) && !rdy_xyz_result) ||
                        ((r_state == CHECK)  && !rdy_xyz_check));
    assign w_err     = r_err;

    // Wait-cycle counter restarts whenever the FSM changes state; error flag
    // is raised by an abort and cleared by the next accepted request
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_to  <= '0;
            r_err <= 1'b0;
        end else begin
            if (((r_state == RESULT) || (r_state == CHECK)) && (w_state_nxt == r_state))
                r_to <= r_to + 1'b1;
            else
                r_to <= '0;
            if (w_accept)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state: each lane method waits on its own RDY
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_accept)           w_state_nxt = START;
            START:  if (rdy_xyz_start)      w_state_nxt = RESULT;
            RESULT: if (rdy_xyz_result)     w_state_nxt = CHECK;
                    else if (w_timeout)     w_state_nxt = RESP;
            CHECK:  if (rdy_xyz_check)      w_state_nxt = RESP;
                    else if (w_timeout)     w_state_nxt = RESP;
            RESP:   if (w_resp_hs)          w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the granted bundle, capture lane results, count completions
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_res   <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[int'(w_gidx)*W +: W];
                        r_b     <= req_b[int'(w_gidx)*W +: W];
                        r_c     <= req_c[int'(w_gidx)*W +: W];
                        r_d     <= req_d[int'(w_gidx)*W +: W];
                        r_owner <= w_gidx;
                        r_ptr   <= c_PTR_W'(rr_next(int'(w_gidx), NUM_REQ));
                    end
                end
                RESULT: if (rdy_xyz_result) r_res <= xyz_result;
                CHECK:  if (rdy_xyz_check)  r_chk <= xyz_check;
                RESP:   if (w_resp_hs && !w_err) r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // FSM outputs: lane arguments and enables only in their own state;
    // acceptance is suppressed while reset is asserted
    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        resp_result  = '0;
        resp_check   = '0;
        resp_err     = 1'b0;
        xyz_start_a  = '0;
        xyz_start_b  = '0;
        en_xyz_start = 1'b0;
        xyz_result_c = '0;
        xyz_check_d  = '0;
        en_xyz_check = 1'b0;
        busy         = (r_state != IDLE);
        done_count   = r_cnt;
        case (r_state)
            IDLE: if (!RST) req_ready = w_grant;
            START: begin
                xyz_start_a  = r_a;
                xyz_start_b  = r_b;
                en_xyz_start = rdy_xyz_start;
            end
            RESULT: xyz_result_c = r_c;
            CHECK: begin
                xyz_check_d  = r_d;
                en_xyz_check = rdy_xyz_check;
            end
            RESP: begin
                resp_valid  = NUM_REQ'(1) << r_owner;
                resp_result = w_err ? '0 : r_res;
                resp_check  = w_err ? '0 : r_chk;
                resp_err    = w_err;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_xyz_rr_scheduler.sv
//============================================================================
// Module      : tb_xyz_rr_scheduler
// Description : Self-checking bench for xyz_rr_scheduler. The lane model
//               answers result = c + 4 and check = d - 4 (mod 2^W).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_xyz_rr_scheduler;

    localparam int W  = 5;
    localparam int N  = 3;
    localparam int CW = 4;
`ifdef XYZ_SCHED_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*W-1:0] req_c = '0;
    logic [N*W-1:0] req_d = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_result;
    logic [W-1:0]   resp_check;
    logic           resp_err;
    logic [N-1:0]   resp_ready = '1;
    logic [W-1:0]   xyz_start_a;
    logic [W-1:0]   xyz_start_b;
    logic           en_xyz_start;
    logic           rdy_xyz_start = 1'b1;
    logic [W-1:0]   xyz_result_c;
    logic [W-1:0]   xyz_result;
    logic           rdy_xyz_result = 1'b1;
    logic [W-1:0]   xyz_check_d;
    logic           en_xyz_check;
    logic [W-1:0]   xyz_check;
    logic           rdy_xyz_check = 1'b1;
    logic           busy;
    logic [CW-1:0]  done_count;

    xyz_rr_scheduler #(
        .W       (W),
        .NUM_REQ (N),
        .CNT_W   (CW)
`ifdef XYZ_SCHED_TIMEOUT_EN
        ,
        .TO_CYC  (TO)
`endif
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_c          (req_c),
        .req_d          (req_d),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_result    (resp_result),
        .resp_check     (resp_check),
        .resp_err       (resp_err),
        .resp_ready     (resp_ready),
        .xyz_start_a    (xyz_start_a),
        .xyz_start_b    (xyz_start_b),
        .en_xyz_start   (en_xyz_start),
        .rdy_xyz_start  (rdy_xyz_start),
        .xyz_result_c   (xyz_result_c),
        .xyz_result     (xyz_result),
        .rdy_xyz_result (rdy_xyz_result),
        .xyz_check_d    (xyz_check_d),
        .en_xyz_check   (en_xyz_check),
        .xyz_check      (xyz_check),
        .rdy_xyz_check  (rdy_xyz_check),
        .busy           (busy),
        .done_count     (done_count)
    );

    always #5 CLK = ~CLK;

    // Lane model
    assign xyz_result = xyz_result_c + W'(4);
    assign xyz_check  = xyz_check_d - W'(4);

    typedef struct {
        int           rq;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] er;
        logic [W-1:0] ec;
    } vec_t;

    typedef struct {
        logic [N-1:0] oh;
        logic [W-1:0] rs;
        logic [W-1:0] ck;
        logic         err;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    exp_t          sbq[$];
    logic          exp_err = 1'b0;
    logic [CW-1:0] exp_done = '0;
    vec_t          tab[4];
    exp_t          m_e;
    int            m_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req(input int rq, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
        req_a[rq*W +: W] = a;
        req_b[rq*W +: W] = b;
        req_c[rq*W +: W] = c;
        req_d[rq*W +: W] = d;
        req_valid = N'(1) << rq;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge CLK); #1;
            n++;
        end while (busy && n < 50);
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, want 0", n);
        end
    endtask

    // One transaction with every RDY high: checks each cycle of the 5-cycle period
    task automatic run_one(input int rq, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d,
                           input logic [W-1:0] er, input logic [W-1:0] ec);
        logic [N-1:0] oh;
        oh = N'(1) << rq;
        drive_req(rq, a, b, c, d);
        #1;
        chk("c0_req_ready", 32'(req_ready), 32'(oh));
        chk("c0_busy", 32'(busy), 0);
        @(negedge CLK); req_valid = '0; #1;
        chk("c1_en_start", 32'(en_xyz_start), 1);
        chk("c1_start_a", 32'(xyz_start_a), 32'(a));
        chk("c1_start_b", 32'(xyz_start_b), 32'(b));
        @(negedge CLK); #1;
        chk("c2_result_c", 32'(xyz_result_c), 32'(c));
        chk("c2_en_start", 32'(en_xyz_start), 0);
        @(negedge CLK); #1;
        chk("c3_en_check", 32'(en_xyz_check), 1);
        chk("c3_check_d", 32'(xyz_check_d), 32'(d));
        @(negedge CLK); #1;
        chk("c4_resp_valid", 32'(resp_valid), 32'(oh));
        chk("c4_resp_result", 32'(resp_result), 32'(er));
        chk("c4_resp_check", 32'(resp_check), 32'(ec));
        exp_done = exp_done + 1'b1;
        @(negedge CLK); #1;
        chk("c5_busy", 32'(busy), 0);
        chk("c5_done_count", 32'(done_count), 32'(exp_done));
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake
    always @(negedge CLK) begin
        #3;
        if (!RST && ((req_valid & req_ready) != '0)) begin
            m_g = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) m_g = i;
            m_e.oh  = req_ready;
            m_e.err = exp_err;
            m_e.rs  = exp_err ? '0 : req_c[m_g*W +: W] + W'(4);
            m_e.ck  = exp_err ? '0 : req_d[m_g*W +: W] - W'(4);
            sbq.push_back(m_e);
        end
        if ((resp_valid & resp_ready) != '0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: response 0x%0h with no accepted request", resp_valid);
            end else begin
                m_e = sbq.pop_front();
                chk("sb_owner", 32'(resp_valid), 32'(m_e.oh));
                chk("sb_result", 32'(resp_result), 32'(m_e.rs));
                chk("sb_check", 32'(resp_check), 32'(m_e.ck));
                chk("sb_err", 32'(resp_err), 32'(m_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{1, 5'd3,  5'd4,  5'd5,  5'd6,  5'd9,  5'd2};
        tab[1] = '{0, 5'd31, 5'd0,  5'd28, 5'd3,  5'd0,  5'd31};
        tab[2] = '{2, 5'd10, 5'd21, 5'd17, 5'd4,  5'd21, 5'd0};
        tab[3] = '{1, 5'd1,  5'd2,  5'd30, 5'd15, 5'd2,  5'd11};

        // Reset state
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_en_start", 32'(en_xyz_start), 0);
        chk("rst_en_check", 32'(en_xyz_check), 0);
        chk("rst_done_count", 32'(done_count), 0);
        chk("rst_resp_err", 32'(resp_err), 0);

        // Table-driven single transactions
        for (int i = 0; i < 4; i++)
            run_one(tab[i].rq, tab[i].a, tab[i].b, tab[i].c, tab[i].d, tab[i].er, tab[i].ec);

        // Start stalled for 3 cycles
        rdy_xyz_start = 1'b0;
        drive_req(2, 5'd7, 5'd8, 5'd9, 5'd10);
        #1;
        chk("stall_req_ready", 32'(req_ready), 32'b100);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK); req_valid = '0; #1;
            chk("stall_en_start", 32'(en_xyz_start), 0);
            chk("stall_start_a", 32'(xyz_start_a), 7);
            chk("stall_busy", 32'(busy), 1);
        end
        @(negedge CLK); rdy_xyz_start = 1'b1; #1;
        chk("stall_fire", 32'(en_xyz_start), 1);
        chk("stall_start_b", 32'(xyz_start_b), 8);
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("stall_c6_no_resp", 32'(resp_valid), 0);
        @(negedge CLK); #1;
        chk("stall_c7_resp", 32'(resp_valid), 32'b100);
        chk("stall_c7_result", 32'(resp_result), 13);
        exp_done = exp_done + 1'b1;
        @(negedge CLK); #1;
        chk("stall_done_count", 32'(done_count), 32'(exp_done));

        // Owner withholds resp_ready while others assert theirs
        drive_req(0, 5'd1, 5'd2, 5'd3, 5'd4);
        #1;
        chk("hold_req_ready", 32'(req_ready), 32'b001);
        @(negedge CLK);
        req_valid = '0;
        drive_req(1, 5'd11, 5'd12, 5'd20, 5'd25);
        @(negedge CLK);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); resp_ready = 3'b110; #1;
            chk("hold_resp_valid", 32'(resp_valid), 32'b001);
            chk("hold_resp_result", 32'(resp_result), 7);
            chk("hold_resp_check", 32'(resp_check), 0);
            chk("hold_no_grant", 32'(req_ready), 0);
        end
        @(negedge CLK); resp_ready = '1; #1;
        chk("hold_release", 32'(resp_valid), 32'b001);
        exp_done = exp_done + 1'b1;
        @(negedge CLK); #1;
        chk("hold_next_grant", 32'(req_ready), 32'b010);
        @(negedge CLK); req_valid = '0;
        wait_idle();
        exp_done = exp_done + 1'b1;
        chk("hold_done_count", 32'(done_count), 32'(exp_done));

        // Reset pulsed while in CHECK
        drive_req(1, 5'd2, 5'd3, 5'd4, 5'd5);
        @(negedge CLK); req_valid = '0;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("rstc_in_check", 32'(en_xyz_check), 1);
        RST = 1'b1;
        sbq.delete();
        @(negedge CLK); RST = 1'b0; #1;
        exp_done = '0;
        chk("rstc_busy", 32'(busy), 0);
        chk("rstc_resp_valid", 32'(resp_valid), 0);
        chk("rstc_en_check", 32'(en_xyz_check), 0);
        chk("rstc_check_d", 32'(xyz_check_d), 0);
        chk("rstc_resp_result", 32'(resp_result), 0);
        chk("rstc_done_count", 32'(done_count), 0);

        // All requesters valid: rotation 0,1,2,0 at cycles 0,5,10,15
        for (int i = 0; i < N; i++)
            drive_req(i, W'(i + 1), W'(i + 2), W'(8 * i + 3), W'(4 * i + 1));
        req_valid = '1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic [N-1:0] eo;
            if (cyc > 0) @(negedge CLK);
            #1;
            eo = (cyc % 5 == 0) ? (N'(1) << ((cyc / 5) % 3)) : '0;
            chk("rot_grant", 32'(req_ready), 32'(eo));
        end
        @(negedge CLK); req_valid = '0;
        wait_idle();
        exp_done = exp_done + CW'(4);
        chk("rot_done_count", 32'(done_count), 32'(exp_done));

        // Back-to-back single-requester traffic until done_count wraps
        for (int t = 0; t < 12; t++) begin
            logic [W-1:0] c, d;
            c = W'(2 * t + 1);
            d = W'(t + 5);
            run_one(t % 3, W'(t), W'(t + 1), c, d, c + W'(4), d - W'(4));
        end
        chk("cnt_wrap", 32'(done_count), 0);

`ifdef XYZ_SCHED_TIMEOUT_EN
        // Result never ready: abort with resp_err eight cycles into RESULT
        exp_err = 1'b1;
        rdy_xyz_result = 1'b0;
        drive_req(0, 5'd1, 5'd1, 5'd1, 5'd1);
        @(negedge CLK); req_valid = '0;
        for (int k = 2; k <= 9; k++) @(negedge CLK);
        #1;
        chk("to_c9_no_resp", 32'(resp_valid), 0);
        @(negedge CLK); #1;
        chk("to_resp_valid", 32'(resp_valid), 32'b001);
        chk("to_resp_err", 32'(resp_err), 1);
        chk("to_resp_result", 32'(resp_result), 0);
        @(negedge CLK); #1;
        chk("to_busy", 32'(busy), 0);
        chk("to_done_count", 32'(done_count), 32'(exp_done));
        exp_err = 1'b0;
        rdy_xyz_result = 1'b1;
`endif

        @(negedge CLK); #1;
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xyz_rr_scheduler.md
Name: xyz_rr_scheduler

Overview:
- Round-robin scheduler that shares one XYZ sub-interface lane (start / result / check method triple, BSV RDY/EN protocol) between NUM_REQ independent requesters.
- Accepts one operand bundle (a, b, c, d) per transaction.
- Sequences start(a,b), then result(c), then check(d) on the lane, and returns both values to the owning requester.
- Sits between requester logic and one XYZ_n port group of the mkDesign_11-style unit; one instance per lane.

Parameters:
- W, 5, operand/result width
- NUM_REQ, 3, number of requesters (2..8)
- CNT_W, 16, width of completed-transaction counter
- TO_CYC, 64, watchdog limit in cycles (only with the optional feature)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_a, req_b, req_c, req_d  in  NUM_REQ*W each  flattened operands; slice i belongs to requester i
- req_ready  out  NUM_REQ  one-hot acceptance strobe
- resp_valid  out  NUM_REQ  one-hot response valid
- resp_result  out  W  captured result value
- resp_check  out  W  captured check value
- resp_err  out  1  timeout abort flag (feature only, else tied 0)
- resp_ready  in  NUM_REQ  per-requester response accept
- xyz_start_a, xyz_start_b  out  W  start arguments
- en_xyz_start  out  1  start enable
- rdy_xyz_start  in  1  start ready
- xyz_result_c  out  W  result argument
- xyz_result  in  W  result value
- rdy_xyz_result  in  1  result ready
- xyz_check_d  out  W  check argument
- en_xyz_check  out  1  check enable
- xyz_check  in  W  check value
- rdy_xyz_check  in  1  check ready
- busy  out  1  state != IDLE
- done_count  out  CNT_W  completed transactions, wraps

Behaviour:
- Reset (sync, RST=1 at posedge):
  - State -> IDLE, rr_ptr -> 0, owner -> 0, done_count -> 0, all captured/latched registers -> 0.
  - All outputs 0.
  - Any in-flight transaction is dropped silently; no response is issued.
- Arbitration in IDLE (combinational):
  - Grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 only in IDLE; accept = req_valid[g] & req_ready[g].
  - On accept: latch a/b/c/d slice g; owner <- g; rr_ptr <- (g+1) mod NUM_REQ; state -> START.
- START:
  - xyz_start_a/b = latched operands; en_xyz_start = rdy_xyz_start.
  - When rdy_xyz_start=1, go to RESULT; otherwise hold.
- RESULT:
  - xyz_result_c = latched c.
  - When rdy_xyz_result=1, capture xyz_result and go to CHECK.
- CHECK:
  - xyz_check_d = latched d; en_xyz_check = rdy_xyz_check.
  - When rdy_xyz_check=1, capture xyz_check and go to RESP.
- RESP:
  - resp_valid[owner]=1 and resp_result/resp_check stable until resp_ready[owner].
  - On handshake: done_count += 1 (wraps) and state -> IDLE.
  - resp_ready of non-owners is ignored.
- Outputs outside their state:
  - en_* are 0.
  - xyz_* argument outputs are 0.
  - resp_result/resp_check are 0 outside RESP.
- Latency and throughput:
  - With all RDY held high: accept at cycle 0, en_xyz_start at 1, result capture at 2, en_xyz_check at 3, resp_valid at 4.
  - A new accept is possible the cycle after the RESP handshake, so minimum period is 5 cycles.
- Boundaries:
  - req_valid deasserting while not granted: no effect.
  - All requesters valid: strict rotation 0,1,2,0...
  - A single requester gets back-to-back service.
  - done_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro XYZ_SCHED_TIMEOUT_EN.
- Defined: a cycle counter runs in RESULT and CHECK and clears on each state entry. On reaching TO_CYC-1 without the awaited RDY, go to RESP with resp_err=1, resp_result=0, resp_check=0. done_count is not incremented for error responses.
- Undefined: no counter; wait indefinitely; resp_err tied 0.

Decomposition:
- Package xyz_sched_pkg:
  - state enum (IDLE, START, RESULT, CHECK, RESP), 3 bits
  - W default constant
  - rr-next helper function
- One sub-module, xyz_rr_arbiter: combinational rotating-priority one-hot grant from req_valid and rr_ptr.

Test Plan:
- All RDY=1; requester 1 sends a=3, b=4, c=5, d=6; lane returns result=9, check=2 -> req_ready[1] at cycle 0, en_xyz_start at cycle 1, resp_valid[1] at cycle 4 with resp_result=9 and resp_check=2; done_count=1.
- All three requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,0 at cycles 0,5,10,15.
- rdy_xyz_start low for 3 cycles -> en_xyz_start stays 0 and operands hold; start fires on the first RDY cycle; response delayed by 3 cycles.
- resp_ready[owner] held low 4 cycles, with resp_ready asserted on other requesters -> resp_valid and data stable; no new grant until the owner handshakes.
- RST pulsed while in CHECK -> next cycle busy=0 and all outputs 0; no resp_valid; the next grant goes to requester 0.
- With XYZ_SCHED_TIMEOUT_EN and TO_CYC=8, rdy_xyz_result stuck 0 -> resp_valid with resp_err=1 eight cycles after entering RESULT; done_count unchanged.
